// File: rtl/drift_curve_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drift_curve_gen_if : run configuration inputs and sample stream outputs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface drift_curve_gen_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 18,
   parameter int G_W    = 18,
   parameter int T_W    = 9
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                   iStart;
   logic                   iHold;
   logic [T_W-1:0]         iTLast;
   logic [N_CH*DATA_W-1:0] iS;
   logic [N_CH*G_W-1:0]    iG;
   logic [DATA_W-1:0]      oData;
   logic [T_W-1:0]         oAddr;
   logic [CH_W-1:0]        oCh;
   logic                   oValid;
   logic                   oBusy;
   logic                   oDone;

   modport master (
      output iStart, iHold, iTLast, iS, iG,
      input  oData, oAddr, oCh, oValid, oBusy, oDone
   );

   modport slave (
      input  iStart, iHold, iTLast, iS, iG,
      output oData, oAddr, oCh, oValid, oBusy, oDone
   );
endinterface
`default_nettype wire

// File: rtl/drift_curve_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drift_curve_gen : S_c(t) = S0_c * G_c^t via one shared pipelined multiplier|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module drift_curve_gen #(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 18,
   parameter int S_FRAC   = 14,
   parameter int G_W      = 18,
   parameter int G_FRAC   = 16,
   parameter int T_W      = 9,
   parameter int MULT_LAT = 3
) (
   input  wire logic        CLK,
   input  wire logic        iRSTn,
   drift_curve_gen_if.slave bus
);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int N_ST   = 1 << CH_W;
   localparam int R      = (N_CH > MULT_LAT) ? N_CH : MULT_LAT;
   localparam int P_W    = (R > 1) ? $clog2(R) : 1;
   localparam int PROD_W = DATA_W + G_W;
   localparam int RND_W  = PROD_W + 1 - G_FRAC;

   localparam logic [P_W:0]      C_NCH    = (P_W + 1)'(N_CH);
   localparam logic [P_W-1:0]    C_RLAST  = P_W'(R - 1);
   localparam logic [CH_W-1:0]   C_CHLAST = CH_W'(N_CH - 1);
   localparam logic [PROD_W:0]   C_HALF   = (PROD_W + 1)'(1) << (G_FRAC - 1);
   localparam logic [DATA_W-1:0] C_SMAX   = '1;

   if (N_CH < 1 || MULT_LAT < 1 || G_FRAC < 1 || G_FRAC > G_W || S_FRAC > DATA_W) begin : g_bad_params
      $error("drift_curve_gen: illegal parameter set");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [T_W-1:0]    t_q, t_d;
   logic [T_W-1:0]    tlast_q, tlast_d;
   logic [P_W-1:0]    pos_q, pos_d;
   logic [DATA_W-1:0] s_q [N_ST];
   logic [DATA_W-1:0] s_d [N_ST];
   logic [G_W-1:0]    g_q [N_ST];
   logic [G_W-1:0]    g_d [N_ST];
   logic [DATA_W-1:0] data_q, data_d;
   logic [T_W-1:0]    addr_q, addr_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              w_start;
   logic              w_issue;
   logic              w_last;
   logic [CH_W-1:0]   w_ch;
   logic [PROD_W-1:0] w_prod;
   logic              w_wb_vld;
   logic [CH_W-1:0]   w_wb_ch;
   logic [PROD_W-1:0] w_wb_prod;
   logic [RND_W-1:0]  w_rnd;
   logic [DATA_W-1:0] w_wb_val;

   // Slots pos >= N_CH are the idle tail of a round that covers multiplier latency.
   assign w_start = (state_q == ST_IDLE) && bus.iStart;
   assign w_issue = (state_q == ST_RUN) && !bus.iHold && ({1'b0, pos_q} < C_NCH);
   assign w_ch    = pos_q[CH_W-1:0];
   assign w_last  = w_issue && (t_q == tlast_q) && (w_ch == C_CHLAST);
   assign w_prod  = PROD_W'(s_q[w_ch]) * PROD_W'(g_q[w_ch]);

   if (MULT_LAT == 1) begin : g_nopipe
      assign w_wb_vld  = w_issue && !w_last;
      assign w_wb_ch   = w_ch;
      assign w_wb_prod = w_prod;
   end else begin : g_pipe
      logic [MULT_LAT-2:0] pv_q;
      logic [CH_W-1:0]     pc_q [MULT_LAT-1];
      logic [PROD_W-1:0]   pp_q [MULT_LAT-1];

      // A new start flushes leftovers of the previous run so they cannot clobber S0.
      always_ff @(posedge CLK or negedge iRSTn) begin
         if (!iRSTn) begin
            pv_q <= '0;
            for (int i = 0; i < MULT_LAT - 1; i++) begin
               pc_q[i] <= '0;
               pp_q[i] <= '0;
            end
         end else begin
            pv_q[0] <= w_issue && !w_last;
            pc_q[0] <= w_ch;
            pp_q[0] <= w_prod;
            for (int i = 1; i < MULT_LAT - 1; i++) begin
               pv_q[i] <= pv_q[i-1] && !w_start;
               pc_q[i] <= pc_q[i-1];
               pp_q[i] <= pp_q[i-1];
            end
         end
      end

      assign w_wb_vld  = pv_q[MULT_LAT-2];
      assign w_wb_ch   = pc_q[MULT_LAT-2];
      assign w_wb_prod = pp_q[MULT_LAT-2];
   end

   assign w_rnd    = RND_W'(({1'b0, w_wb_prod} + C_HALF) >> G_FRAC);
   assign w_wb_val = (w_rnd > RND_W'(C_SMAX)) ? C_SMAX : w_rnd[DATA_W-1:0];

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      tlast_d = tlast_q;
      pos_d   = pos_q;
      s_d     = s_q;
      g_d     = g_q;
      data_d  = data_q;
      addr_d  = addr_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (w_wb_vld) begin
         s_d[w_wb_ch] = w_wb_val;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.iStart) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
               tlast_d = bus.iTLast;
               t_d     = '0;
               pos_d   = '0;
               for (int c = 0; c < N_CH; c++) begin
                  s_d[c] = bus.iS[c*DATA_W +: DATA_W];
                  g_d[c] = bus.iG[c*G_W +: G_W];
               end
            end
         end
         ST_RUN: begin
            if (!bus.iHold) begin
               if (w_issue) begin
                  data_d  = s_q[w_ch];
                  addr_d  = t_q;
                  ch_d    = w_ch;
                  valid_d = 1'b1;
               end
               if (w_last) begin
                  state_d = ST_LAST;
               end else if (pos_q == C_RLAST) begin
                  pos_d = '0;
                  t_d   = t_q + T_W'(1);
               end else begin
                  pos_d = pos_q + P_W'(1);
               end
            end
         end
         ST_LAST: begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         // Extra cycle keeps a start presented alongside the done pulse from being taken.
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q <= ST_IDLE;
         t_q     <= '0;
         tlast_q <= '0;
         pos_q   <= '0;
         for (int c = 0; c < N_ST; c++) begin
            s_q[c] <= '0;
            g_q[c] <= '0;
         end
         data_q  <= '0;
         addr_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         tlast_q <= tlast_d;
         pos_q   <= pos_d;
         s_q     <= s_d;
         g_q     <= g_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.oData  = data_q;
   assign bus.oAddr  = addr_q;
   assign bus.oCh    = ch_q;
   assign bus.oValid = valid_q;
   assign bus.oBusy  = busy_q;
   assign bus.oDone  = done_q;
endmodule
`default_nettype wire
